// File: rtl/tdm_rx_buffer.sv
// -----------------------------------------------------------------------------
// tdm_rx_buffer
//
// Purpose:
//   Receives one TDM audio stream (ADC side), deserializes each slot into an
//   IO_WIDTH-bit two's-complement sample (MSB first on the wire) and stores a
//   whole frame in one half of a ping-pong buffer.  The DSP core reads the
//   other half through a registered read port.  frame_tick pulses for one
//   clk cycle whenever a freshly completed frame becomes readable.
//
//   sclk_in, fs_in and sdata_in are asynchronous to clk.  They pass through
//   2-FF synchronizers; sclk gets an extra history stage for rise detection.
//   Correct operation needs f_clk >= 4 * f_sclk.
//
//   Framing: fs is high on the sclk rise that carries slot 0 MSB (no 1-bit
//   delay).  Only bits 0..IO_WIDTH-1 of each SLOT_WIDTH-bit slot are kept.
//
// Ports:
//   clk         in   core clock
//   reset_n     in   asynchronous active-low reset
//   sclk_in     in   TDM bit clock (async)
//   fs_in       in   TDM frame sync (async)
//   sdata_in    in   TDM serial data (async)
//   rd_addr     in   channel read address
//   rd_data     out  sample at rd_addr in the read bank, 1-cycle latency
//   frame_tick  out  1-cycle pulse: new frame readable
//   frame_ack   in   core pulse: finished with the current read bank
//   overrun     out  sticky: bank swap with no ack since the previous tick
//   frame_err   out  sticky: frame sync seen mid-frame
//   err_clr     in   clears overrun and frame_err (a same-cycle set wins)
//
// Optional feature (macro TDM_RX_CLIP_DETECT_EN):
//   clip_flags  out  per-channel sticky full-scale detect
//   clip_clr    in   clears clip_flags (a same-cycle set wins)
//   With the macro undefined these ports and their logic do not exist.
// -----------------------------------------------------------------------------
module tdm_rx_buffer #(
    parameter int IO_WIDTH      = 24,
    parameter int SLOT_WIDTH    = 32,
    parameter int NUM_CHANNELS  = 8,
    parameter int CH_ADDR_WIDTH = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     sclk_in,
    input  logic                     fs_in,
    input  logic                     sdata_in,
    input  logic [CH_ADDR_WIDTH-1:0] rd_addr,
    output logic [IO_WIDTH-1:0]      rd_data,
    output logic                     frame_tick,
    input  logic                     frame_ack,
    output logic                     overrun,
    output logic                     frame_err,
    input  logic                     err_clr
`ifdef TDM_RX_CLIP_DETECT_EN
    ,
    output logic [NUM_CHANNELS-1:0]  clip_flags,
    input  logic                     clip_clr
`endif
);

    localparam int BIT_CNT_W = (SLOT_WIDTH > 1) ? $clog2(SLOT_WIDTH) : 1;
    localparam int MEM_DEPTH = 2 * NUM_CHANNELS;

    localparam logic [BIT_CNT_W-1:0]     LAST_DATA_BIT = BIT_CNT_W'(IO_WIDTH - 1);
    localparam logic [BIT_CNT_W-1:0]     LAST_SLOT_BIT = BIT_CNT_W'(SLOT_WIDTH - 1);
    localparam logic [CH_ADDR_WIDTH-1:0] LAST_CH       = CH_ADDR_WIDTH'(NUM_CHANNELS - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RECV    = 2'd1,
        ST_WAIT_FS = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // Synchronizers and edge detection
    // ------------------------------------------------------------------
    // Index 0 is the first stage, 1 the settled stage, 2 (sclk only) the
    // history stage used for rise detection.
    logic [2:0] sclk_sync_q;
    logic [1:0] fs_sync_q;
    logic [1:0] sdata_sync_q;

    // fs level seen at the previous sclk rise; fs_rise is judged on the
    // bit grid rather than on clk so that fs and data stay bit-aligned.
    logic       fs_prev_q, fs_prev_d;

    logic       sclk_rise;
    logic       fs_bit;
    logic       data_bit;
    logic       fs_rise;

    assign sclk_rise = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign fs_bit    = fs_sync_q[1];
    assign data_bit  = sdata_sync_q[1];
    assign fs_rise   = sclk_rise & fs_bit & ~fs_prev_q;

    always_comb begin
        fs_prev_d = fs_prev_q;
        if (sclk_rise) begin
            fs_prev_d = fs_bit;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM and deserializer
    // ------------------------------------------------------------------
    state_t                   state_q, state_d;
    logic [BIT_CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [CH_ADDR_WIDTH-1:0] slot_cnt_q, slot_cnt_d;
    logic [IO_WIDTH-1:0]      shift_q, shift_d;

    // Sample write staged one clk after its last bit is captured.
    logic                     wr_en_q, wr_en_d;
    logic                     wr_last_q, wr_last_d;
    logic [CH_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [IO_WIDTH-1:0]      wr_data_q, wr_data_d;

    // Capture position for the current bit: either the running counters or
    // slot 0 bit 0 when this bit opens a frame.
    logic                     capture;
    logic [BIT_CNT_W-1:0]     cap_bit;
    logic [CH_ADDR_WIDTH-1:0] cap_slot;
    logic                     ferr_set;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        slot_cnt_d = slot_cnt_q;
        shift_d    = shift_q;
        wr_en_d    = 1'b0;
        wr_last_d  = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        capture    = 1'b0;
        cap_bit    = bit_cnt_q;
        cap_slot   = slot_cnt_q;
        ferr_set   = 1'b0;

        if (sclk_rise) begin
            case (state_q)
                ST_IDLE, ST_WAIT_FS: begin
                    if (fs_rise) begin
                        capture  = 1'b1;
                        cap_bit  = '0;
                        cap_slot = '0;
                    end
                end
                ST_RECV: begin
                    capture = 1'b1;
                    // Early frame sync: drop the partial frame and let this
                    // bit start a new one.  Already-written samples of the
                    // dropped frame are simply overwritten later.
                    if (fs_rise) begin
                        ferr_set = 1'b1;
                        cap_bit  = '0;
                        cap_slot = '0;
                    end
                end
                default: begin
                    capture = 1'b0;
                end
            endcase
        end

        if (capture) begin
            state_d = ST_RECV;

            if (cap_bit <= LAST_DATA_BIT) begin
                shift_d = {shift_q[IO_WIDTH-2:0], data_bit};
            end

            if (cap_bit == LAST_DATA_BIT) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cap_slot;
                wr_data_d = {shift_q[IO_WIDTH-2:0], data_bit};
                wr_last_d = (cap_slot == LAST_CH);
            end

            if (cap_bit == LAST_SLOT_BIT) begin
                bit_cnt_d = '0;
                if (cap_slot == LAST_CH) begin
                    slot_cnt_d = '0;
                    state_d    = ST_WAIT_FS;
                end else begin
                    slot_cnt_d = cap_slot + 1'b1;
                end
            end else begin
                bit_cnt_d  = cap_bit + 1'b1;
                slot_cnt_d = cap_slot;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank control, handshake and error flags
    // ------------------------------------------------------------------
    logic                swap_q, swap_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic                ack_pend_q, ack_pend_d;
    logic                overrun_q, overrun_d;
    logic                frame_err_q, frame_err_d;
    logic                rd_bank_sel;
    logic [IO_WIDTH-1:0] rd_data_q, rd_data_d;

    logic [IO_WIDTH-1:0] mem_q [MEM_DEPTH];

    always_comb begin
        // Swap one clk after the final sample of the frame lands in memory.
        swap_d    = wr_en_q & wr_last_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        if (swap_q) begin
            wr_bank_d = ~wr_bank_q;
            rd_bank_d = wr_bank_q;
        end

        // An ack in the swap cycle retires the previous tick; the new tick
        // then becomes the one awaiting acknowledgement.
        ack_pend_d = ack_pend_q;
        if (swap_q) begin
            ack_pend_d = 1'b1;
        end else if (frame_ack) begin
            ack_pend_d = 1'b0;
        end

        overrun_d   = (swap_q & ack_pend_q & ~frame_ack) | (overrun_q & ~err_clr);
        frame_err_d = ferr_set | (frame_err_q & ~err_clr);

        // A read issued in the swap cycle must already see the new bank.
        rd_bank_sel = swap_q ? wr_bank_q : rd_bank_q;
        rd_data_d   = mem_q[{rd_bank_sel, rd_addr}];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q  <= '0;
            fs_sync_q    <= '0;
            sdata_sync_q <= '0;
            fs_prev_q    <= 1'b0;
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            slot_cnt_q   <= '0;
            shift_q      <= '0;
            wr_en_q      <= 1'b0;
            wr_last_q    <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            swap_q       <= 1'b0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
            ack_pend_q   <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            sclk_sync_q  <= {sclk_sync_q[1:0], sclk_in};
            fs_sync_q    <= {fs_sync_q[0], fs_in};
            sdata_sync_q <= {sdata_sync_q[0], sdata_in};
            fs_prev_q    <= fs_prev_d;
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            slot_cnt_q   <= slot_cnt_d;
            shift_q      <= shift_d;
            wr_en_q      <= wr_en_d;
            wr_last_q    <= wr_last_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            swap_q       <= swap_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            ack_pend_q   <= ack_pend_d;
            overrun_q    <= overrun_d;
            frame_err_q  <= frame_err_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Sample RAM: intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en_q) begin
            mem_q[{wr_bank_q, wr_addr_q}] <= wr_data_q;
        end
    end

    assign rd_data    = rd_data_q;
    assign frame_tick = swap_q;
    assign overrun    = overrun_q;
    assign frame_err  = frame_err_q;

`ifdef TDM_RX_CLIP_DETECT_EN
    // ------------------------------------------------------------------
    // Full-scale detect on every sample written
    // ------------------------------------------------------------------
    localparam logic [IO_WIDTH-1:0] FS_POS = {1'b0, {(IO_WIDTH-1){1'b1}}};
    localparam logic [IO_WIDTH-1:0] FS_NEG = {1'b1, {(IO_WIDTH-1){1'b0}}};

    logic [NUM_CHANNELS-1:0] clip_q, clip_d;
    logic [NUM_CHANNELS-1:0] clip_set;

    always_comb begin
        clip_set = '0;
        if (wr_en_q && ((wr_data_q == FS_POS) || (wr_data_q == FS_NEG))) begin
            clip_set[wr_addr_q] = 1'b1;
        end
        clip_d = clip_set | (clip_q & ~{NUM_CHANNELS{clip_clr}});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clip_q <= '0;
        end else begin
            clip_q <= clip_d;
        end
    end

    assign clip_flags = clip_q;
`endif

endmodule

// File: tb/tb_tdm_rx_buffer.sv
// -----------------------------------------------------------------------------
// tb_tdm_rx_buffer
//
// Drives TDM frames into tdm_rx_buffer and checks every frame_tick against a
// queue of expected frames.  A frame-level model (bank contents, pending
// acknowledgement, sticky flags) is updated when a frame is queued; the
// monitor pops one entry per tick, checks the flags, sweeps all channels
// right after the swap and again part-way through the following frame.
// -----------------------------------------------------------------------------
module tb_tdm_rx_buffer;

    localparam int IO_WIDTH      = 24;
    localparam int SLOT_WIDTH    = 32;
    localparam int NUM_CHANNELS  = 8;
    localparam int CH_ADDR_WIDTH = 3;
    localparam int W             = IO_WIDTH * NUM_CHANNELS;
    localparam int SCLK_HALF     = 30;
    localparam logic [IO_WIDTH-1:0] FS_POS = 24'h7FFFFF;
    localparam logic [IO_WIDTH-1:0] FS_NEG = 24'h800000;

    // ack_mode: 0 = never ack, 1 = ack after reading, 2 = ack in swap cycle
    typedef struct {
        logic [W-1:0]            data;
        int                      ack_mode;
        logic                    exp_ovr;
        logic                    exp_ferr;
        logic [NUM_CHANNELS-1:0] exp_clip;
    } exp_t;

    logic                     clk       = 1'b0;
    logic                     reset_n   = 1'b0;
    logic                     sclk_in   = 1'b0;
    logic                     fs_in     = 1'b0;
    logic                     sdata_in  = 1'b0;
    logic [CH_ADDR_WIDTH-1:0] rd_addr   = '0;
    logic [IO_WIDTH-1:0]      rd_data;
    logic                     frame_tick;
    logic                     frame_ack = 1'b0;
    logic                     overrun;
    logic                     frame_err;
    logic                     err_clr   = 1'b0;
`ifdef TDM_RX_CLIP_DETECT_EN
    logic [NUM_CHANNELS-1:0]  clip_flags;
    logic                     clip_clr  = 1'b0;
`endif

    exp_t exp_q[$];
    int   checks        = 0;
    int   errors        = 0;
    int   tick_count    = 0;
    int   frames_pushed = 0;
    logic mon_busy      = 1'b0;

    // Frame-level reference state
    logic                    model_pending = 1'b0;
    logic                    model_ovr     = 1'b0;
    logic                    model_ferr    = 1'b0;
    logic [NUM_CHANNELS-1:0] model_clip    = '0;

    tdm_rx_buffer #(
        .IO_WIDTH      (IO_WIDTH),
        .SLOT_WIDTH    (SLOT_WIDTH),
        .NUM_CHANNELS  (NUM_CHANNELS),
        .CH_ADDR_WIDTH (CH_ADDR_WIDTH)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .sclk_in    (sclk_in),
        .fs_in      (fs_in),
        .sdata_in   (sdata_in),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_tick (frame_tick),
        .frame_ack  (frame_ack),
        .overrun    (overrun),
        .frame_err  (frame_err),
        .err_clr    (err_clr)
`ifdef TDM_RX_CLIP_DETECT_EN
        ,
        .clip_flags (clip_flags),
        .clip_clr   (clip_clr)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_clip_update(input logic [W-1:0] d, input int nslots);
        logic [IO_WIDTH-1:0] s;
        for (int ch = 0; ch < nslots; ch++) begin
            s = d[ch*IO_WIDTH +: IO_WIDTH];
            if (s == FS_POS || s == FS_NEG) model_clip[ch] = 1'b1;
        end
    endtask

    task automatic push_frame(input logic [W-1:0] d, input int mode);
        exp_t e;
        if (model_pending && mode != 2) model_ovr = 1'b1;
        model_pending = (mode != 1);
        model_clip_update(d, NUM_CHANNELS);
        e.data     = d;
        e.ack_mode = mode;
        e.exp_ovr  = model_ovr;
        e.exp_ferr = model_ferr;
        e.exp_clip = model_clip;
        exp_q.push_back(e);
        frames_pushed++;
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_bit(input logic b, input logic f);
        sdata_in = b;
        fs_in    = f;
        #SCLK_HALF sclk_in = 1'b1;
        #SCLK_HALF sclk_in = 1'b0;
    endtask

    task automatic send_slot(input logic [IO_WIDTH-1:0] s, input logic first);
        for (int b = 0; b < SLOT_WIDTH; b++) begin
            if (b < IO_WIDTH) send_bit(s[IO_WIDTH-1-b], first && (b == 0));
            else              send_bit(1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] d, input int nslots);
        for (int s = 0; s < nslots; s++) send_slot(d[s*IO_WIDTH +: IO_WIDTH], s == 0);
        if (nslots == NUM_CHANNELS) begin
            repeat ($urandom_range(0, 3)) send_bit(1'($urandom_range(0, 1)), 1'b0);
        end
    endtask

    task automatic expect_frame(input logic [W-1:0] d, input int mode);
        push_frame(d, mode);
        send_frame(d, NUM_CHANNELS);
    endtask

    function automatic logic [W-1:0] fill_frame(input logic [IO_WIDTH-1:0] v, input logic inc);
        logic [W-1:0] d;
        for (int ch = 0; ch < NUM_CHANNELS; ch++)
            d[ch*IO_WIDTH +: IO_WIDTH] = inc ? v + IO_WIDTH'(ch) : v;
        return d;
    endfunction

    function automatic logic [W-1:0] rand_frame();
        logic [W-1:0] d;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) d[ch*IO_WIDTH +: IO_WIDTH] = IO_WIDTH'($urandom);
        return d;
    endfunction

    task automatic wait_idle();
        int n = 0;
        repeat (4) @(negedge clk);
        while (mon_busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check_val("monitor_idle_timeout", 32'(mon_busy), 32'd0);
    endtask

    task automatic pulse_err_clr();
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        @(negedge clk);
        model_ovr  = 1'b0;
        model_ferr = 1'b0;
    endtask

    // ---------------- monitor / scoreboard ----------------
    task automatic sweep(input exp_t e, input string tag);
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            rd_addr = CH_ADDR_WIDTH'(ch);
            @(negedge clk);
            check_val($sformatf("%s_ch%0d", tag, ch), 32'(rd_data), 32'(e.data[ch*IO_WIDTH +: IO_WIDTH]));
        end
    endtask

    initial begin : monitor_proc
        exp_t e;
        forever begin
            @(negedge clk);
            if (frame_tick === 1'b1) begin
                mon_busy = 1'b1;
                tick_count++;
                if (exp_q.size() == 0) begin
                    check_val("unexpected_tick", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.ack_mode == 2) frame_ack = 1'b1;
                    // First read is issued in the swap cycle itself.
                    rd_addr = '0;
                    @(negedge clk);
                    frame_ack = 1'b0;
                    check_val("overrun", 32'(overrun), 32'(e.exp_ovr));
                    check_val("frame_err", 32'(frame_err), 32'(e.exp_ferr));
`ifdef TDM_RX_CLIP_DETECT_EN
                    check_val("clip_flags", 32'(clip_flags), 32'(e.exp_clip));
`endif
                    check_val("swap_read_ch0", 32'(rd_data), 32'(e.data[IO_WIDTH-1:0]));
                    sweep(e, "rd");
                    if (e.ack_mode == 1) begin
                        frame_ack = 1'b1;
                        @(negedge clk);
                        frame_ack = 1'b0;
                    end
                    // Re-read while the next frame is filling the other bank.
                    repeat (600) @(negedge clk);
                    sweep(e, "hold");
                end
                mon_busy = 1'b0;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #1500000;
        $display("FAIL watchdog actual=timeout required=finish");
        errors++;
        checks++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // ---------------- stimulus ----------------
    initial begin : stim_proc
        logic [W-1:0] d;

        repeat (5) @(negedge clk);
        check_val("reset_rd_data", 32'(rd_data), 32'd0);
        check_val("reset_frame_tick", 32'(frame_tick), 32'd0);
        check_val("reset_overrun", 32'(overrun), 32'd0);
        check_val("reset_frame_err", 32'(frame_err), 32'd0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);

        // Basic frame and ping-pong
        expect_frame(fill_frame(24'h100000, 1'b1), 1);
        expect_frame(fill_frame(24'hAAAAAA, 1'b0), 1);
        expect_frame(fill_frame(24'h555555, 1'b0), 1);
        for (int i = 0; i < 3; i++) expect_frame(rand_frame(), 1);

        // Overrun: two unacked ticks, then clear
        expect_frame(rand_frame(), 0);
        expect_frame(rand_frame(), 0);
        wait_idle();
        pulse_err_clr();
        check_val("overrun_after_clr", 32'(overrun), 32'd0);

        // Ack in the swap cycle retires the old tick; the new one stays pending
        expect_frame(rand_frame(), 2);
        expect_frame(rand_frame(), 1);
        wait_idle();
        pulse_err_clr();
        check_val("overrun_after_clr2", 32'(overrun), 32'd0);

        // Early frame sync after slot 3
        d = rand_frame();
        model_clip_update(d, 4);
        model_ferr = 1'b1;
        send_frame(d, 4);
        expect_frame(fill_frame(24'h100000, 1'b1), 0);
        expect_frame(rand_frame(), 0);
        wait_idle();

        // Reset part-way through slot 5
        d = fill_frame(24'h7FFFFF, 1'b0);
        send_frame(d, 5);
        for (int b = 0; b < 10; b++) send_bit(d[5*IO_WIDTH + IO_WIDTH - 1 - b], 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        check_val("midreset_rd_data", 32'(rd_data), 32'd0);
        check_val("midreset_frame_tick", 32'(frame_tick), 32'd0);
        check_val("midreset_overrun", 32'(overrun), 32'd0);
        check_val("midreset_frame_err", 32'(frame_err), 32'd0);
`ifdef TDM_RX_CLIP_DETECT_EN
        check_val("midreset_clip", 32'(clip_flags), 32'd0);
`endif
        model_pending = 1'b0;
        model_ovr     = 1'b0;
        model_ferr    = 1'b0;
        model_clip    = '0;
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        expect_frame(fill_frame(24'h100000, 1'b1), 0);
        wait_idle();

`ifdef TDM_RX_CLIP_DETECT_EN
        d = fill_frame(24'h100000, 1'b1);
        d[2*IO_WIDTH +: IO_WIDTH] = FS_POS;
        d[6*IO_WIDTH +: IO_WIDTH] = FS_NEG;
        expect_frame(d, 1);
        wait_idle();
        check_val("clip_set", 32'(clip_flags), 32'h44);
        @(negedge clk);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        @(negedge clk);
        model_clip = '0;
        check_val("clip_clr", 32'(clip_flags), 32'(model_clip));
`endif

        repeat (20) @(negedge clk);
        wait_idle();
        check_val("queue_empty", 32'(exp_q.size()), 32'd0);
        check_val("tick_count", 32'(tick_count), 32'(frames_pushed));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
